// File: rtl/pdu_gen_mc.sv
// pdu_gen_mc: turns one packet plus its rule-ID stream into a PDU in the PCIe
// ring buffer (header flit, payload flits, packed rule flits), forwards the
// packet downstream and emits one metadata record per packet.
// Optional build macro: PDU_GEN_MC_STATS_EN adds three 32-bit event counters.
// Handshake: a beat transfers on any cycle where its valid and ready are both
// high; a valid source holds its beat stable until it transfers.
// in_meta_ready and pduid_ready are one-cycle pop pulses, not ready signals.
module pdu_gen_mc #(
    parameter int DW     = 512,
    parameter int RULE_W = 16,
    parameter int AW     = 12,
    parameter int IDW    = 10,
    parameter int META_W = 128,
    parameter int BSWAP  = 1,
    localparam int EW    = $clog2(DW/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [EW-1:0]     in_empty,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RULE_W-1:0] in_rule_data,
    input  logic              in_rule_last,
    input  logic              in_rule_valid,
    output logic              in_rule_ready,
    input  logic [META_W-1:0] in_meta_data,
    input  logic [15:0]       in_meta_flits,
    input  logic              in_meta_valid,
    output logic              in_meta_ready,
    output logic [DW-1:0]     rb_wr_data,
    output logic              rb_wr_sop,
    output logic              rb_wr_eop,
    output logic [AW-1:0]     rb_wr_addr,
    output logic              rb_wr_en,
    input  logic [AW-1:0]     rb_base_addr,
    input  logic              rb_almost_full,
    output logic              rb_update_valid,
    output logic [AW-1:0]     rb_update_size,
    input  logic              disable_pcie,
    input  logic [IDW-1:0]    pduid_data,
    input  logic              pduid_valid,
    output logic              pduid_ready,
    output logic [DW-1:0]     pdu_out_data,
    output logic              pdu_out_sop,
    output logic              pdu_out_eop,
    output logic [EW-1:0]     pdu_out_empty,
    output logic              pdu_out_valid,
    input  logic              pdu_out_ready,
    input  logic              pdu_out_almost_full,
    output logic [IDW-1:0]    pdumeta_id,
    output logic [15:0]       pdumeta_size,
    output logic [15:0]       pdumeta_flits,
    output logic              pdumeta_check,
    output logic              pdumeta_valid,
    input  logic              pdumeta_ready,
    output logic [2:0]        state_dbg
`ifdef PDU_GEN_MC_STATS_EN
    ,
    output logic [31:0]       stat_check_pdus,
    output logic [31:0]       stat_nocheck_pdus,
    output logic [31:0]       stat_rule_flits
`endif
);
    localparam int NB  = DW / 8;
    localparam int RPF = DW / RULE_W;
    localparam int SW  = $clog2(RPF + 1);

    typedef enum logic [2:0] {IDLE, PKT, RULE, HEAD, WAIT} state_t;
    state_t state, next_state;

    logic [AW-1:0]     offset;
    logic [15:0]       size, pkt_flits, rule_cnt, rule_flits, total_flits, beat_bytes;
    logic [16:0]       size_sum;
    logic [DW-1:0]     rule_buf;
    logic [SW-1:0]     rule_slot;
    logic              wr_en_d, wr_sop_d, wr_eop_d, rule_wr, nocheck_go;
    logic [AW-1:0]     wr_addr_d;
    logic [DW-1:0]     wr_data_d, payload_data;
    logic              unused_meta_flits;

    function automatic logic [DW-1:0] byte_rev(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
        return r;
    endfunction

    assign state_dbg         = state;
    assign unused_meta_flits = ^in_meta_flits;
    assign payload_data      = (BSWAP != 0) ? byte_rev(in_data) : in_data;
    assign beat_bytes        = in_eop ? 16'(NB) - 16'(in_empty) : 16'(NB);
    assign size_sum          = {1'b0, size} + {1'b0, beat_bytes};
    assign total_flits       = 16'd1 + pkt_flits + rule_flits;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state, stream readies and the ring-buffer write decision.
    // The current rule flit is written only when the next rule or the
    // terminator arrives, so the final rule flit always carries eop without
    // having to rewrite an earlier flit.
    always_comb begin
        next_state    = state;
        in_ready      = 1'b0;
        in_rule_ready = 1'b0;
        wr_en_d       = 1'b0;
        wr_sop_d      = 1'b0;
        wr_eop_d      = 1'b0;
        wr_addr_d     = rb_base_addr + AW'(1) + offset;
        wr_data_d     = '0;
        rule_wr       = 1'b0;
        nocheck_go    = 1'b0;
        case (state)
            IDLE: begin
                if (in_meta_valid && pduid_valid && !rb_almost_full && !pdu_out_almost_full)
                    next_state = PKT;
            end
            PKT: begin
                in_ready = !pdu_out_valid || pdu_out_ready;
                if (in_valid && in_ready) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = payload_data;
                    if (in_sop) wr_addr_d = rb_base_addr + AW'(1);
                    if (in_eop) next_state = RULE;
                end
            end
            RULE: begin
                in_rule_ready = 1'b1;
                if (in_rule_valid) begin
                    if (!in_rule_last) begin
                        if (rule_slot == SW'(RPF)) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = rule_buf;
                            rule_wr   = 1'b1;
                        end
                    end else begin
                        if (rule_cnt != 16'd0) begin
                            wr_en_d   = 1'b1;
                            wr_eop_d  = 1'b1;
                            wr_data_d = rule_buf;
                            rule_wr   = 1'b1;
                        end
                        if (rule_cnt != 16'd0 && !disable_pcie) begin
                            next_state = HEAD;
                        end else begin
                            next_state = WAIT;
                            nocheck_go = 1'b1;
                        end
                    end
                end
            end
            HEAD: begin
                wr_en_d    = 1'b1;
                wr_sop_d   = 1'b1;
                wr_addr_d  = rb_base_addr;
                wr_data_d  = DW'({in_meta_data, pduid_data, rule_cnt, size, total_flits});
                next_state = WAIT;
            end
            WAIT: begin
                if (pdumeta_valid && pdumeta_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-PDU counters and the rule packing buffer, cleared while idle
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            offset     <= '0;
            size       <= '0;
            pkt_flits  <= '0;
            rule_cnt   <= '0;
            rule_flits <= '0;
            rule_buf   <= '0;
            rule_slot  <= '0;
        end else begin
            if (state == PKT && in_valid && in_ready) begin
                if (in_sop) begin
                    offset    <= AW'(1);
                    size      <= beat_bytes;
                    pkt_flits <= 16'd1;
                end else begin
                    offset    <= offset + AW'(1);
                    size      <= size_sum[16] ? 16'hFFFF : size_sum[15:0];
                    pkt_flits <= pkt_flits + 16'd1;
                end
            end
            if (state == RULE && in_rule_valid) begin
                if (rule_wr) begin
                    offset     <= offset + AW'(1);
                    rule_flits <= rule_flits + 16'd1;
                end
                if (!in_rule_last) begin
                    rule_cnt <= rule_cnt + 16'd1;
                    if (rule_slot == SW'(RPF)) begin
                        rule_buf  <= DW'(in_rule_data);
                        rule_slot <= SW'(1);
                    end else begin
                        rule_buf[int'(rule_slot)*RULE_W +: RULE_W] <= in_rule_data;
                        rule_slot <= rule_slot + SW'(1);
                    end
                end
            end
        end
    end

    // Registered ring-buffer write port and commit/pop pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_wr_en        <= 1'b0;
            rb_wr_sop       <= 1'b0;
            rb_wr_eop       <= 1'b0;
            rb_wr_addr      <= '0;
            rb_wr_data      <= '0;
            rb_update_valid <= 1'b0;
            rb_update_size  <= '0;
            pduid_ready     <= 1'b0;
            in_meta_ready   <= 1'b0;
        end else begin
            rb_wr_en        <= wr_en_d;
            rb_wr_sop       <= wr_sop_d;
            rb_wr_eop       <= wr_eop_d;
            rb_wr_addr      <= wr_addr_d;
            rb_wr_data      <= wr_data_d;
            rb_update_valid <= (state == HEAD);
            pduid_ready     <= (state == HEAD);
            in_meta_ready   <= (state == HEAD) || nocheck_go;
            if (state == HEAD) rb_update_size <= AW'(total_flits);
        end
    end

    // Single-stage forwarding register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            pdu_out_valid <= 1'b0;
            pdu_out_data  <= '0;
            pdu_out_sop   <= 1'b0;
            pdu_out_eop   <= 1'b0;
            pdu_out_empty <= '0;
        end else if (in_valid && in_ready) begin
            pdu_out_valid <= 1'b1;
            pdu_out_data  <= in_data;
            pdu_out_sop   <= in_sop;
            pdu_out_eop   <= in_eop;
            pdu_out_empty <= in_empty;
        end else if (pdu_out_ready) begin
            pdu_out_valid <= 1'b0;
        end
    end

    // Metadata record, held until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            pdumeta_valid <= 1'b0;
            pdumeta_id    <= '0;
            pdumeta_size  <= '0;
            pdumeta_flits <= '0;
            pdumeta_check <= 1'b0;
        end else if (state == HEAD) begin
            pdumeta_valid <= 1'b1;
            pdumeta_id    <= pduid_data;
            pdumeta_size  <= size;
            pdumeta_flits <= total_flits;
            pdumeta_check <= 1'b1;
        end else if (nocheck_go) begin
            pdumeta_valid <= 1'b1;
            pdumeta_id    <= '0;
            pdumeta_size  <= size;
            pdumeta_flits <= pkt_flits + rule_flits + 16'(rule_wr);
            pdumeta_check <= 1'b0;
        end else if (pdumeta_ready) begin
            pdumeta_valid <= 1'b0;
        end
    end

`ifdef PDU_GEN_MC_STATS_EN
    // Free-running event counters, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_check_pdus   <= '0;
            stat_nocheck_pdus <= '0;
            stat_rule_flits   <= '0;
        end else begin
            if (state == HEAD) stat_check_pdus   <= stat_check_pdus + 32'd1;
            if (nocheck_go)    stat_nocheck_pdus <= stat_nocheck_pdus + 32'd1;
            if (rule_wr)       stat_rule_flits   <= stat_rule_flits + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pdu_gen_mc.md
Name: pdu_gen_mc

Overview:
- Parametrised successor of the single-flit-width PDU generator. Converts one packet and its rule-ID stream into a PDU in the PCIe ring buffer: a header flit, then the payload flits, then the packed rule-ID flits.
- Forwards the packet downstream and emits one PDU metadata record per packet.
- New over the previous generation:
  - parametrised data width;
  - multiple rule IDs packed per flit;
  - ring-address wrap-around;
  - byte swap selectable by parameter;
  - a proper ready/valid output pipeline.
- Sits between the rule-matching pipeline and the PCIe ring-buffer/DMA engine.

Parameters:
DW, 512, data width in bits; multiple of 64 and of RULE_W
RULE_W, 16, rule-ID width in bits
AW, 12, ring-buffer address width; ring depth is 2**AW flits
IDW, 10, PDU-ID width
META_W, 128, opaque tuple/protocol width copied into the header
BSWAP, 1, 1 = byte-reverse payload flits on the ring-buffer write port

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data/in_sop/in_eop/in_empty/in_valid  in  DW/1/1/log2(DW/8)/1  packet stream
in_ready  out  1  packet accept
in_rule_data/in_rule_last/in_rule_valid  in  RULE_W/1/1  rule stream; a last beat is a terminator and carries no rule
in_rule_ready  out  1  rule accept
in_meta_data/in_meta_flits/in_meta_valid  in  META_W/16/1  per-packet metadata
in_meta_ready  out  1  one-cycle pop pulse
rb_wr_data/rb_wr_sop/rb_wr_eop/rb_wr_addr/rb_wr_en  out  DW/1/1/AW/1  ring-buffer write port
rb_base_addr  in  AW  next free ring slot
rb_almost_full  in  1  ring-buffer backpressure
rb_update_valid/rb_update_size  out  1/AW  commit pulse and flit count
disable_pcie  in  1  force NOCHECK on all packets
pduid_data/pduid_valid  in  IDW/1  free PDU-ID list
pduid_ready  out  1  one-cycle pop pulse
pdu_out_data/sop/eop/empty/valid  out  DW/1/1/log2(DW/8)/1  forwarded packet
pdu_out_ready  in  1  downstream ready
pdu_out_almost_full  in  1  downstream backpressure
pdumeta_id/size/flits/check/valid  out  IDW/16/16/1/1  PDU metadata record
pdumeta_ready  in  1  metadata accept

Behaviour:
- Reset: every valid, ready, en and pulse output is 0. All counters are 0. rb_wr_addr = 0. State = IDLE.
- Handshakes: a beat transfers on valid & ready.
  - in_ready = (state==PKT) & (!pdu_out_valid | pdu_out_ready). This is a single registered stage with no beat loss or duplication.
  - pdu_out_* presents the accepted beat one cycle later and holds it while !pdu_out_ready.
- IDLE -> PKT when in_meta_valid & pduid_valid & !rb_almost_full & !pdu_out_almost_full.
- PKT, per accepted beat:
  - slot offset increments;
  - rb write to base+1+k (mod 2**AW);
  - size += (eop ? DW/8-in_empty : DW/8);
  - pkt_flits += 1;
  - on sop, offset and size restart.
  - eop -> RULE.
- RULE: in_rule_ready = 1.
  - Rules pack into slot j = rule_cnt % (DW/RULE_W) at bits [j*RULE_W +: RULE_W]; unused slots are 0.
  - A full flit writes to the next address.
  - On the terminator:
    - if rule_cnt>0, flush any partial flit with eop=1; if the flit is empty, mark the last written rule flit eop=1;
    - rule_cnt>0 & !disable_pcie -> HEAD;
    - otherwise -> WAIT with check=0 and pdumeta_id=0. Payload already written is left uncommitted and no PDU ID is popped.
- HEAD: one write.
  - Address = rb_base_addr, sop=1.
  - Data = {meta, pduid_data, rule_cnt, size, total_flits}, zero-padded.
  - total_flits = 1 + pkt_flits + ceil(rule_cnt*RULE_W/DW).
  - Pulse pduid_ready, in_meta_ready and rb_update_valid; rb_update_size = total_flits.
  - Issue the metadata record with check=1. -> WAIT.
- WAIT: pdumeta_valid is held until pdumeta_ready -> IDLE. For NOCHECK packets, in_meta_ready pulses on entry to WAIT.
- Latency: the ring-buffer write port is registered, one cycle after the internal write decision. BSWAP applies to payload flits only, never to header or rule flits.
- Arithmetic: address sums are truncated to AW bits, so the ring wraps naturally. Size is 16-bit and saturates at 16'hFFFF.
- Boundaries:
  - a 0-rule terminator arriving on the first RULE cycle is NOCHECK;
  - exactly DW/RULE_W rules produce one rule flit with no extra flush;
  - a sop without a preceding eop restarts the PDU;
  - rst mid-PDU aborts with no commit and no ID pop.

Optional Feature:
- Macro: PDU_GEN_MC_STATS_EN.
- When defined, adds three 32-bit outputs: stat_check_pdus, stat_nocheck_pdus and stat_rule_flits.
  - Each increments on the corresponding HEAD/WAIT entry or rule-flit write.
  - Each wraps at 2**32 and is cleared by rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. DW=512: 3-flit packet with last empty=10 and 5 rules, base=100.
   - Writes: header at 100 (sop), payload at 101-103, one rule flit at 104 (eop).
   - size=182, rb_update_size=5, one pduid pop, check=1.
2. Same packet with a terminator only.
   - No header write, no rb_update_valid, no pduid_ready.
   - pdumeta check=0, id=0, size=182.
3. base=4094 with AW=12 and a 4-flit PDU.
   - Addresses 4094, 4095, 0, 1.
4. 32 rules then 33 rules.
   - 32 rules: one rule flit, eop on it.
   - 33 rules: two rule flits, the second holding rule 33 in slot 0 and zeros elsewhere; total_flits increases by 1.
5. pdu_out_ready held low for 4 cycles mid-packet.
   - in_ready=0 for those cycles; the output beat is held stable; no beat is lost or duplicated.
6. disable_pcie=1 with 7 rules.
   - check=0, no commit, no ID pop.
   - With PDU_GEN_MC_STATS_EN defined: stat_nocheck_pdus increments by 1.
